// File: rtl/accum_checker_pkg.sv
// Shared types and widths for the accumulator result checker.
// Optional feature macro: ACCUM_CHECKER_OVF_CHECK_EN (see accum_checker.sv).
package accum_checker_pkg;

    localparam int ERR_CNT_W = 8;
    localparam int CHK_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/accum_checker_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: bump when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/accum_checker.sv
// Result checker for the multilayer accumulator: locks onto the observed
// running sum, then predicts every following sample and counts mismatches.
// Define ACCUM_CHECKER_OVF_CHECK_EN to also compare the carry-out input.
module accum_checker
    import accum_checker_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int SYNC_CYCLES = 2,
    parameter int MAX_ERRORS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_sum,
    input  logic                 i_overflow,
    output logic                 o_locked,
    output logic                 o_error,
    output logic                 o_fail,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [CHK_CNT_W-1:0] o_chk_count
);

    localparam int               SYNC_W = (SYNC_CYCLES < 2) ? 1 : $clog2(SYNC_CYCLES + 1);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    acc_state_e        state_q;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  exp_q;
    logic [SYNC_W-1:0] sync_q;
    logic              locked_q;
    logic              error_q;
    logic              fail_q;

    logic [WIDTH-1:0]     sync_nxt;
    logic [WIDTH:0]       lock_sum;
    logic [WIDTH:0]       adv_sum;
    logic                 mismatch;
    logic                 chk_en;
    logic                 err_en;
    logic                 err_hit;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [CHK_CNT_W-1:0] chk_cnt;

    // During SYNC the stream only has to step from its own previous sample.
    assign sync_nxt = prev_q + STEP_W;

    // One extra bit on both sums: the MSB is the predicted carry-out.
    assign lock_sum = {1'b0, i_sum} + STEP_X;
    assign adv_sum  = {1'b0, exp_q} + STEP_X;

`ifdef ACCUM_CHECKER_OVF_CHECK_EN
    logic exp_ovf_q;
    assign mismatch = (i_sum != exp_q) || (i_overflow != exp_ovf_q);
`else
    // Carry is not checked in this build; its bits are deliberately dropped.
    logic unused_carry;
    assign unused_carry = ^{lock_sum[WIDTH], adv_sum[WIDTH], i_overflow};
    assign mismatch     = (i_sum != exp_q);
`endif

    // Counters only move on valid samples seen while locked.
    always_comb begin
        chk_en = 1'b0;
        err_en = 1'b0;
        if ((state_q == CHECK) && i_valid) begin
            chk_en = 1'b1;
            err_en = mismatch;
        end
    end

    // This error is the one that brings the count to the failure threshold.
    assign err_hit = err_en && (err_cnt >= ERR_CNT_W'(MAX_ERRORS - 1));

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (err_en),
        .cnt_o  (err_cnt)
    );

    sat_counter #(.W(CHK_CNT_W)) u_chk_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (chk_en),
        .cnt_o  (chk_cnt)
    );

    // Lock / check / fail sequencing with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            exp_q     <= '0;
            sync_q    <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            fail_q    <= 1'b0;
`ifdef ACCUM_CHECKER_OVF_CHECK_EN
            exp_ovf_q <= 1'b0;
`endif
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        prev_q  <= i_sum;
                        sync_q  <= '0;
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    if (!i_valid) begin
                        state_q <= IDLE;
                    end else begin
                        prev_q <= i_sum;
                        if (i_sum == sync_nxt) begin
                            sync_q <= sync_q + SYNC_W'(1);
                            if (sync_q == SYNC_W'(SYNC_CYCLES - 1)) begin
                                state_q   <= CHECK;
                                locked_q  <= 1'b1;
                                exp_q     <= lock_sum[WIDTH-1:0];
`ifdef ACCUM_CHECKER_OVF_CHECK_EN
                                exp_ovf_q <= lock_sum[WIDTH];
`endif
                            end
                        end else begin
                            sync_q <= '0;
                        end
                    end
                end
                CHECK: begin
                    if (!i_valid) begin
                        // A mismatch on the dropping cycle is discarded.
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end else begin
                        error_q   <= mismatch;
                        // Prediction free-runs so one glitch costs one error.
                        exp_q     <= adv_sum[WIDTH-1:0];
`ifdef ACCUM_CHECKER_OVF_CHECK_EN
                        exp_ovf_q <= adv_sum[WIDTH];
`endif
                        if (err_hit) begin
                            state_q  <= FAIL;
                            locked_q <= 1'b0;
                            fail_q   <= 1'b1;
                        end
                    end
                end
                FAIL: begin
                    fail_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_locked    = locked_q;
    assign o_error     = error_q;
    assign o_fail      = fail_q;
    assign o_err_count = err_cnt;
    assign o_chk_count = chk_cnt;

endmodule

// File: tb/tb_accum_checker.sv
// Self-checking bench for accum_checker: directed table, corner sequences,
// and a randomized stream against a reference model of the checker rules.
module tb_accum_checker;

    localparam int WIDTH = 8;
    localparam int STEP  = 1;
    localparam int SYNC  = 2;
    localparam int MAXE  = 16;
`ifdef ACCUM_CHECKER_OVF_CHECK_EN
    localparam int OE = 1;
`else
    localparam int OE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_sum = 8'h00;
    logic        i_overflow = 1'b0;
    logic        o_locked, o_error, o_fail;
    logic [7:0]  o_err_count;
    logic [15:0] o_chk_count;

    int n_pass = 0;
    int n_tot  = 0;

    accum_checker #(
        .WIDTH(WIDTH), .STEP(STEP), .SYNC_CYCLES(SYNC), .MAX_ERRORS(MAXE)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sum(i_sum),
        .i_overflow(i_overflow), .o_locked(o_locked), .o_error(o_error),
        .o_fail(o_fail), .o_err_count(o_err_count), .o_chk_count(o_chk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Present one sample; returns 1 time unit after the edge that took it.
    task automatic cyc(input bit v, input int s, input bit o);
        i_valid    = v;
        i_sum      = 8'(s);
        i_overflow = o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; i_valid = 1'b0; i_sum = 8'h00; i_overflow = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // mode: 0 waiting for valid, 1 acquiring, 2 checking, 3 failed
    int m_mode, m_prev, m_run, m_exp, m_expovf, m_err, m_chk;
    bit m_error;

    function automatic void m_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_exp = 0; m_expovf = 0;
        m_err = 0; m_chk = 0; m_error = 0;
    endfunction

    function automatic void m_step(input bit v, input int s, input bit o);
        bit bad;
        m_error = 0;
        case (m_mode)
            0: if (v) begin m_prev = s; m_run = 0; m_mode = 1; end
            1: if (!v) m_mode = 0;
               else begin
                   if (s == (m_prev + STEP) % 256) m_run++; else m_run = 0;
                   m_prev = s;
                   if (m_run == SYNC) begin
                       m_mode = 2;
                       m_expovf = ((s + STEP) >= 256) ? 1 : 0;
                       m_exp = (s + STEP) % 256;
                   end
               end
            2: if (!v) m_mode = 0;
               else begin
                   bad = (s != m_exp) || (OE == 1 && int'(o) != m_expovf);
                   if (m_chk < 65535) m_chk++;
                   if (bad) begin
                       m_error = 1;
                       if (m_err < 255) m_err++;
                       if (m_err >= MAXE) m_mode = 3;
                   end
                   m_expovf = ((m_exp + STEP) >= 256) ? 1 : 0;
                   m_exp = (m_exp + STEP) % 256;
               end
            default: ;
        endcase
    endfunction

    function automatic longint m_pack();
        return (longint'(m_mode == 2) << 26) | (longint'(m_error) << 25) |
               (longint'(m_mode == 3) << 24) | (longint'(m_err) << 16) | longint'(m_chk);
    endfunction

    function automatic longint dut_pack();
        return longint'({o_locked, o_error, o_fail, o_err_count, o_chk_count});
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit v; int s; bit o; bit lk; bit er; int ec; int cc;
    } vec_t;
    vec_t tbl[19];

    initial begin
        int pulses;
        int cur, nv, s;
        bit v, o;

        // reset state
        do_reset(3);
        check("rst_locked", o_locked, 0);
        check("rst_error", o_error, 0);
        check("rst_fail", o_fail, 0);
        check("rst_errcnt", o_err_count, 0);
        check("rst_chkcnt", o_chk_count, 0);

        // clean lock: 20 reset cycles then 0x05,0x06,...
        do_reset(20);
        for (int i = 0; i < 512; i++) begin
            cyc(1, (5 + i) % 256, (i > 0 && (5 + i) % 256 == 0));
            if (i == 1) check("lock_early", o_locked, 0);
            if (i == 2) check("lock_lat", o_locked, 1);
        end
        check("clean_errcnt", o_err_count, 0);
        check("clean_chkcnt", o_chk_count, 509);

        // table: lock near wrap, wrap, stray carry, glitch, resync at 0x80
        tbl[0]  = '{1, 'hFB, 0, 0, 0, 0,      0};
        tbl[1]  = '{1, 'hFC, 0, 0, 0, 0,      0};
        tbl[2]  = '{1, 'hFD, 0, 1, 0, 0,      0};
        tbl[3]  = '{1, 'hFE, 0, 1, 0, 0,      1};
        tbl[4]  = '{1, 'hFF, 0, 1, 0, 0,      2};
        tbl[5]  = '{1, 'h00, 1, 1, 0, 0,      3};
        tbl[6]  = '{1, 'h01, 0, 1, 0, 0,      4};
        tbl[7]  = '{1, 'h02, 1, 1, OE[0], OE, 5};
        tbl[8]  = '{1, 'h03, 0, 1, 0, OE,     6};
        tbl[9]  = '{1, 'h55, 0, 1, 1, OE + 1, 7};
        tbl[10] = '{1, 'h05, 0, 1, 0, OE + 1, 8};
        tbl[11] = '{0, 'h06, 0, 0, 0, OE + 1, 8};
        tbl[12] = '{0, 'h00, 0, 0, 0, OE + 1, 8};
        tbl[13] = '{0, 'h00, 0, 0, 0, OE + 1, 8};
        tbl[14] = '{1, 'h80, 0, 0, 0, OE + 1, 8};
        tbl[15] = '{1, 'h81, 0, 0, 0, OE + 1, 8};
        tbl[16] = '{1, 'h82, 0, 1, 0, OE + 1, 8};
        tbl[17] = '{1, 'h83, 0, 1, 0, OE + 1, 9};
        tbl[18] = '{1, 'h99, 0, 1, 1, OE + 2, 10};
        do_reset(2);
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].o);
            check($sformatf("tbl%0d_locked", i), o_locked, tbl[i].lk);
            check($sformatf("tbl%0d_error", i), o_error, tbl[i].er);
            check($sformatf("tbl%0d_errcnt", i), o_err_count, tbl[i].ec);
            check($sformatf("tbl%0d_chkcnt", i), o_chk_count, tbl[i].cc);
        end

        // wrap with the carry missing on the 0x00 sample
        do_reset(2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, (8'hFA + i) % 256, 0);
            pulses += int'(o_error);
        end
        check("wrap_noovf_pulses", pulses, OE);
        check("wrap_noovf_errcnt", o_err_count, OE);

        // persistent offset drives the checker into FAIL
        do_reset(2);
        cyc(1, 'h1E, 0); cyc(1, 'h1F, 0); cyc(1, 'h20, 0);
        check("ofs_locked", o_locked, 1);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 'h22 + i, 0);
            pulses += int'(o_error);
        end
        check("ofs_pulses", pulses, 16);
        check("ofs_fail", o_fail, 1);
        check("ofs_errcnt", o_err_count, 16);
        check("ofs_chkcnt", o_chk_count, 16);
        for (int i = 0; i < 5; i++) cyc(1, 'h40 + i, 0);
        check("fail_chk_frozen", o_chk_count, 16);
        check("fail_err_frozen", o_err_count, 16);
        check("fail_sticky", o_fail, 1);
        check("fail_unlocked", o_locked, 0);

        // asynchronous reset between edges while in FAIL
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_fail", o_fail, 0);
        check("arst_errcnt", o_err_count, 0);
        check("arst_chkcnt", o_chk_count, 0);
        check("arst_locked", o_locked, 0);
        check("arst_error", o_error, 0);

        // randomized stream against the reference model
        do_reset(3);
        m_reset();
        cur = $urandom_range(0, 255);
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c % 500 == 499) begin do_reset(2); m_reset(); end
            v  = ($urandom_range(0, 99) >= 3);
            nv = (cur + STEP) % 256;
            o  = ((cur + STEP) >= 256);
            cur = nv;
            s  = nv;
            r  = $urandom_range(0, 99);
            if (r < 4) s = $urandom_range(0, 255);
            else if (r < 6) o = !o;
            else if (r < 7) begin cur = $urandom_range(0, 255); s = cur; o = 0; end
            cyc(v, s, o);
            m_step(v, s, o);
            check($sformatf("rand%0d", c), dut_pack(), m_pack());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
